// File: rtl/if8080_tx.sv
// 8080 write-bus master: sends the 0x2A/0x2B/0x2C window header, then streams window pixels from RAM.
// Optional abort input enabled by defining IF8080_TX_ABORT_EN.
module if8080_tx #(
  parameter int unsigned COL_NUM_LOG2 = 7,
  parameter int unsigned WR_LOW_CYC   = 2,
  parameter int unsigned WR_HIGH_CYC  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [COL_NUM_LOG2-1:0]   win_startx,
  input  logic [COL_NUM_LOG2-1:0]   win_endx,
  input  logic [4:0]                win_starty,
  input  logic [4:0]                win_endy,
`ifdef IF8080_TX_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      ram_rd_en,
  output logic [COL_NUM_LOG2+4:0]   ram_rd_addr,
  input  logic [15:0]               ram_rd_dat,
  output logic                      mcu_csx,
  output logic                      mcu_wrx,
  output logic                      mcu_rdx,
  output logic                      mcu_dcx,
  output logic [15:0]               mcu_dat
);
  localparam int unsigned AW = COL_NUM_LOG2 + 5;
  localparam int unsigned NW = COL_NUM_LOG2 + 6;
  localparam int unsigned CW = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_FETCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              hdr_idx_q, hdr_idx_d;
  logic                    pix_q, pix_d;
  logic [NW-1:0]           k_q, k_d;
  logic [NW-1:0]           npix_q, npix_d;
  logic [AW-1:0]           base_q, base_d;
  logic [COL_NUM_LOG2-1:0] sx_q, sx_d, ex_q, ex_d;
  logic [4:0]              sy_q, sy_d, ey_q, ey_d;
  logic                    abort_q, abort_d;
  logic                    busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic                    csx_q, csx_d, wrx_q, wrx_d, dcx_q, dcx_d;
  logic [15:0]             dat_q, dat_d;

  logic                    abort_req;
  logic [4:0]              dy;
  logic [COL_NUM_LOG2-1:0] dx;
  logic                    nxt_dcx;
  logic [15:0]             nxt_dat;

`ifdef IF8080_TX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign dy = win_endy - win_starty;
  assign dx = win_endx - win_startx;

  // Header word that follows the one at hdr_idx_q.
  always_comb begin
    nxt_dcx = 1'b1;
    nxt_dat = 16'h002C;
    case (hdr_idx_q)
      3'd0:    nxt_dat = 16'(sx_q);
      3'd1:    nxt_dat = 16'(ex_q);
      3'd2:    begin nxt_dcx = 1'b0; nxt_dat = 16'h002B; end
      3'd3:    nxt_dat = 16'(sy_q);
      3'd4:    nxt_dat = 16'(ey_q);
      default: nxt_dcx = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_idx_d = hdr_idx_q;
    pix_d     = pix_q;
    k_d       = k_q;
    npix_d    = npix_q;
    base_d    = base_q;
    sx_d      = sx_q;
    ex_d      = ex_q;
    sy_d      = sy_q;
    ey_d      = ey_q;
    abort_d   = abort_q;
    rd_addr_d = rd_addr_q;
    dcx_d     = dcx_q;
    dat_d     = dat_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          sx_d      = win_startx;
          ex_d      = win_endx;
          sy_d      = win_starty;
          ey_d      = win_endy;
          base_d    = (AW'(win_starty) << COL_NUM_LOG2) + AW'(win_startx);
          npix_d    = NW'(1) + (NW'(dy) << COL_NUM_LOG2) + NW'(dx);
          k_d       = '0;
          hdr_idx_d = '0;
          pix_d     = 1'b0;
          if ((win_endx < win_startx) || (win_endy < win_starty)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            dcx_d   = 1'b0;
            dat_d   = 16'h002A;
          end
        end
      end
      S_SETUP: begin
        if (pix_q) dat_d = ram_rd_dat;
        cnt_d   = CW'(WR_LOW_CYC - 1);
        state_d = S_LOW;
      end
      S_LOW: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(WR_HIGH_CYC - 1);
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (abort_q || abort_req) begin
          state_d = S_DONE;
        end else if (!pix_q && hdr_idx_q != 3'd6) begin
          hdr_idx_d = hdr_idx_q + 1'b1;
          dcx_d     = nxt_dcx;
          dat_d     = nxt_dat;
          state_d   = S_SETUP;
        end else if (!pix_q) begin
          pix_d     = 1'b1;
          k_d       = '0;
          rd_addr_d = base_q;
          state_d   = S_FETCH;
        end else if (k_q == npix_q - NW'(1)) begin
          state_d = S_DONE;
        end else begin
          k_d       = k_q + NW'(1);
          rd_addr_d = base_q + k_d[AW-1:0];
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort_q || abort_req) begin
          state_d = S_DONE;
        end else begin
          dcx_d   = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && state_q != S_DONE && abort_req) abort_d = 1'b1;

    // Strobes are decoded from the next state so every output comes straight off a flop.
    csx_d   = !(state_d == S_SETUP || state_d == S_LOW || state_d == S_HIGH || state_d == S_FETCH);
    wrx_d   = (state_d != S_LOW);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    rd_en_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hdr_idx_q <= '0;
      pix_q     <= 1'b0;
      k_q       <= '0;
      npix_q    <= '0;
      base_q    <= '0;
      sx_q      <= '0;
      ex_q      <= '0;
      sy_q      <= '0;
      ey_q      <= '0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      csx_q     <= 1'b1;
      wrx_q     <= 1'b1;
      dcx_q     <= 1'b1;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_idx_q <= hdr_idx_d;
      pix_q     <= pix_d;
      k_q       <= k_d;
      npix_q    <= npix_d;
      base_q    <= base_d;
      sx_q      <= sx_d;
      ex_q      <= ex_d;
      sy_q      <= sy_d;
      ey_q      <= ey_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      csx_q     <= csx_d;
      wrx_q     <= wrx_d;
      dcx_q     <= dcx_d;
      dat_q     <= dat_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_rd_en   = rd_en_q;
  assign ram_rd_addr = rd_addr_q;
  assign mcu_csx     = csx_q;
  assign mcu_wrx     = wrx_q;
  assign mcu_rdx     = 1'b1;
  assign mcu_dcx     = dcx_q;
  assign mcu_dat     = dat_q;
endmodule

// File: tb/tb_if8080_tx.sv
// Randomized bench for if8080_tx: a cycle-phase model of the 8080 write protocol plus a word-level scoreboard.
module tb_if8080_tx;
  localparam int unsigned CL = 7;
  localparam int unsigned L  = 2;
  localparam int unsigned H  = 4;
  localparam int unsigned AW = CL + 5;
  localparam int HW = 1 + L + H;
  localparam int PW = 2 + L + H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [CL-1:0] sx = '0, ex = '0;
  logic [4:0] sy = '0, ey = '0;
  logic busy, done, ram_rd_en, mcu_csx, mcu_wrx, mcu_rdx, mcu_dcx;
  logic [AW-1:0] ram_rd_addr;
  logic [15:0] ram_rd_dat = '0;
  logic [15:0] mcu_dat;

  logic [15:0] mem [0:(1<<AW)-1];
  logic [16:0] got_w[$];
  int csx_low, done_cnt, rd_cnt;
  logic [AW-1:0] last_addr;
  logic wrx_prev;
  int total = 0;
  int bad = 0;

  if8080_tx #(.COL_NUM_LOG2(CL), .WR_LOW_CYC(L), .WR_HIGH_CYC(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .win_startx(sx), .win_endx(ex), .win_starty(sy), .win_endy(ey),
`ifdef IF8080_TX_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_dat(ram_rd_dat), .mcu_csx(mcu_csx), .mcu_wrx(mcu_wrx), .mcu_rdx(mcu_rdx),
    .mcu_dcx(mcu_dcx), .mcu_dat(mcu_dat)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      if (ram_rd_en) ram_rd_dat <= mem[ram_rd_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus observer: words are taken on each wrx rising edge while selected.
  initial begin
    wrx_prev = 1'b1;
    forever begin
      @(negedge clk);
      chk("rdx_high", {31'b0, mcu_rdx}, 32'd1);
      if (!rst) begin
        if (mcu_wrx && !wrx_prev && !mcu_csx) got_w.push_back({mcu_dcx, mcu_dat});
        if (!mcu_csx) csx_low++;
        if (ram_rd_en) begin rd_cnt++; last_addr = ram_rd_addr; end
      end
      if (done) done_cnt++;
      wrx_prev = mcu_wrx;
    end
  end

  // Expected {csx,wrx,rd_en,done,busy} at cycle c after the start edge; T = cycles with csx low.
  function automatic logic [4:0] exp_vec(input int c, input int t);
    int ph;
    if (c > t) return 5'b11000;
    if (c == t) return 5'b11011;
    if (c < 7 * HW) begin
      ph = c % HW;
      return {1'b0, !(ph >= 1 && ph <= L), 1'b0, 1'b0, 1'b1};
    end
    ph = (c - 7 * HW) % PW;
    return {1'b0, !(ph >= 2 && ph <= L + 1), ph == 0, 1'b0, 1'b1};
  endfunction

  function automatic logic [16:0] exp_word(input int i, input logic [CL-1:0] a_sx, a_ex,
                                           input logic [4:0] a_sy, a_ey, input int base);
    case (i)
      0: return {1'b0, 16'h002A};
      1: return {1'b1, 16'(a_sx)};
      2: return {1'b1, 16'(a_ex)};
      3: return {1'b0, 16'h002B};
      4: return {1'b1, 16'(a_sy)};
      5: return {1'b1, 16'(a_ey)};
      6: return {1'b0, 16'h002C};
      default: return {1'b1, mem[base + i - 7]};
    endcase
  endfunction

  // ws < 0 means the full window; busy_at/abort_at/rst_at < 0 disable those events.
  task automatic run(input logic [CL-1:0] a_sx, a_ex, input logic [4:0] a_sy, a_ey,
                     input int ws_in, input int busy_at, input int abort_at, input int rst_at);
    bit valid;
    int n, base, ws, t, nw;
    logic [4:0] v;
    valid = (a_ex >= a_sx) && (a_ey >= a_sy);
    n = 1 + ((int'(a_ey) - int'(a_sy)) << CL) + (int'(a_ex) - int'(a_sx));
    base = (int'(a_sy) << CL) + int'(a_sx);
    ws = !valid ? 0 : (ws_in < 0 ? 7 + n : ws_in);
    t = (ws <= 7) ? ws * HW : 7 * HW + (ws - 7) * PW;
    got_w.delete();
    csx_low = 0; done_cnt = 0; rd_cnt = 0;
    @(posedge clk); #1;
    sx = a_sx; ex = a_ex; sy = a_sy; ey = a_ey; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= t + 1; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_vec", {27'b0, mcu_csx, mcu_wrx, ram_rd_en, done, busy}, {27'b0, 5'b11000});
        chk("rst_bus", {mcu_dcx, mcu_dat, ram_rd_addr}, {1'b1, 16'h0, {AW{1'b0}}});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);
        return;
      end
      v = exp_vec(c, t);
      chk($sformatf("cyc%0d_vec", c), {27'b0, mcu_csx, mcu_wrx, ram_rd_en, done, busy}, {27'b0, v});
      if (v[2]) chk("rd_addr", {20'b0, ram_rd_addr}, base + (c - 7 * HW) / PW);
      if (c == busy_at) begin
        start = 1'b1; sx = 0; ex = 0; sy = 0; ey = 0;
      end
      if (c == busy_at + 1) start = 1'b0;
      if (c == abort_at) abort = 1'b1;
      if (c == abort_at + 1) abort = 1'b0;
    end
    #1;
    chk("word_count", got_w.size(), ws);
    nw = (got_w.size() < ws) ? got_w.size() : ws;
    for (int i = 0; i < nw; i++)
      chk($sformatf("word%0d", i), {15'b0, got_w[i]}, {15'b0, exp_word(i, a_sx, a_ex, a_sy, a_ey, base)});
    chk("csx_low_cycles", csx_low, t);
    chk("done_once", done_cnt, 1);
  endtask

  logic [16:0] lit_w [0:7];
  logic [CL-1:0] rx0, rx1;
  logic [4:0] ry0, ry1;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    mem[389] = 16'hBEEF;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {mcu_csx, mcu_wrx, mcu_dcx, mcu_dat, ram_rd_en, ram_rd_addr, busy, done},
          {1'b1, 1'b1, 1'b1, 16'h0, 1'b0, {AW{1'b0}}, 1'b0, 1'b0});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single pixel, pinned by literal values.
    run(7'd5, 7'd5, 5'd3, 5'd3, -1, -1, -1, -1);
    lit_w = '{17'h0002A, 17'h10005, 17'h10005, 17'h0002B, 17'h10003, 17'h10003, 17'h0002C, 17'h1BEEF};
    chk("single_words", got_w.size(), 8);
    for (int i = 0; i < 8 && i < got_w.size(); i++)
      chk($sformatf("single_lit%0d", i), {15'b0, got_w[i]}, {15'b0, lit_w[i]});
    chk("single_csx57", csx_low, 57);
    chk("single_rd_cnt", rd_cnt, 1);
    chk("single_rd_addr", {20'b0, last_addr}, 389);

    // Row-spanning window.
    run(7'd0, 7'd1, 5'd0, 5'd1, -1, -1, -1, -1);
    chk("span_rd_cnt", rd_cnt, 130);
    chk("span_csx", csx_low, 7 * 7 + 130 * 8);

    // Random valid windows.
    for (int r = 0; r < 4; r++) begin
      rx0 = 7'($urandom_range(0, 127));
      rx1 = 7'($urandom_range(int'(rx0), (int'(rx0) + 3 > 127) ? 127 : int'(rx0) + 3));
      ry0 = 5'($urandom_range(0, 31));
      ry1 = 5'($urandom_range(int'(ry0), (int'(ry0) + 1 > 31) ? 31 : int'(ry0) + 1));
      run(rx0, rx1, ry0, ry1, -1, -1, -1, -1);
    end

    // Invalid windows.
    run(7'd10, 7'd9, 5'd0, 5'd0, -1, -1, -1, -1);
    chk("invalid_no_csx", csx_low, 0);
    run(7'd0, 7'd0, 5'd4, 5'd3, -1, -1, -1, -1);

    // Start while busy, and a start coincident with DONE.
    run(7'd2, 7'd4, 5'd1, 5'd1, -1, 20, -1, -1);
    run(7'd2, 7'd4, 5'd1, 5'd1, -1, 7 * HW + 3 * PW, -1, -1);

    // Reset during the 3rd pixel's LOW phase.
    run(7'd0, 7'd7, 5'd2, 5'd2, -1, -1, -1, 7 * HW + 2 * PW + 2);

`ifdef IF8080_TX_ABORT_EN
    run(7'd3, 7'd6, 5'd1, 5'd2, 2, -1, HW + 1, -1);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
